// File: rtl/ks_adder_pkg.sv
`default_nettype none
// ============================================================================
// Package : ks_adder_pkg
// Brief   : Shared constants and helpers for the Kogge-Stone pipelined adder.
// Rev     : 1.0
// ============================================================================
package ks_adder_pkg;

   localparam int KS_MIN_WIDTH = 4;
   localparam int KS_MAX_WIDTH = 64;

   function automatic int ks_levels(input int width);
      return $clog2(width);
   endfunction

   function automatic int ks_latency(input int width);
      return ks_levels(width) + 2;
   endfunction

   function automatic bit ks_width_ok(input int width);
      return (width >= KS_MIN_WIDTH) && (width <= KS_MAX_WIDTH) &&
             ((width & (width - 1)) == 0);
   endfunction

   // Saturation bounds, returned 64 bits wide; callers slice to WIDTH.
   function automatic logic [63:0] ks_sat_max(input int width);
      return (64'd1 << (width - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] ks_sat_min(input int width);
      return 64'd1 << (width - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ks_pipe_adder_if.sv
`default_nettype none
// ============================================================================
// Interface : ks_pipe_adder_if
// Brief     : Operand and result handshakes of ks_pipe_adder.
//             The sat signal exists only with KS_PIPE_ADDER_SAT_EN.
// Rev       : 1.0
// ============================================================================
interface ks_pipe_adder_if
   import ks_adder_pkg::*;
#(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
`ifdef KS_PIPE_ADDER_SAT_EN
   logic             sat;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
`ifdef KS_PIPE_ADDER_SAT_EN
      output sat,
`endif
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
`ifdef KS_PIPE_ADDER_SAT_EN
      input  sat,
`endif
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface
`default_nettype wire

// File: rtl/ks_prefix_level.sv
`default_nettype none
// ============================================================================
// Module : ks_prefix_level
// Brief  : One registered Kogge-Stone prefix level merging spans DIST apart.
// Rev    : 1.0
// ============================================================================
module ks_prefix_level
   import ks_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIST  = 1,
   parameter int AUXW  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv_i,
   input  logic             v_i,
   input  logic [WIDTH-1:0] p_i,
   input  logic [WIDTH-1:0] gg_i,
   input  logic [WIDTH-1:0] pp_i,
   input  logic [AUXW-1:0]  aux_i,
   output logic             v_o,
   output logic [WIDTH-1:0] p_o,
   output logic [WIDTH-1:0] gg_o,
   output logic [WIDTH-1:0] pp_o,
   output logic [AUXW-1:0]  aux_o
);

   logic [WIDTH-1:0] w_gg;
   logic [WIDTH-1:0] w_pp;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= DIST) begin : g_merge
         assign w_gg[i] = gg_i[i] | (pp_i[i] & gg_i[i-DIST]);
         assign w_pp[i] = pp_i[i] & pp_i[i-DIST];
      end else begin : g_pass
         assign w_gg[i] = gg_i[i];
         assign w_pp[i] = pp_i[i];
      end
   end

   logic             v_q,   v_d;
   logic [WIDTH-1:0] p_q,   p_d;
   logic [WIDTH-1:0] gg_q,  gg_d;
   logic [WIDTH-1:0] pp_q,  pp_d;
   logic [AUXW-1:0]  aux_q, aux_d;

   always_comb begin
      v_d   = v_q;
      p_d   = p_q;
      gg_d  = gg_q;
      pp_d  = pp_q;
      aux_d = aux_q;
      if (adv_i) begin
         v_d   = v_i;
         p_d   = p_i;
         gg_d  = w_gg;
         pp_d  = w_pp;
         aux_d = aux_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= 1'b0;
         p_q   <= '0;
         gg_q  <= '0;
         pp_q  <= '0;
         aux_q <= '0;
      end else begin
         v_q   <= v_d;
         p_q   <= p_d;
         gg_q  <= gg_d;
         pp_q  <= pp_d;
         aux_q <= aux_d;
      end
   end

   assign v_o   = v_q;
   assign p_o   = p_q;
   assign gg_o  = gg_q;
   assign pp_o  = pp_q;
   assign aux_o = aux_q;

endmodule
`default_nettype wire

// File: rtl/ks_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module : ks_pipe_adder
// Brief  : Pipelined Kogge-Stone adder/subtractor with global-stall handshake.
//          Optional signed saturation enabled by KS_PIPE_ADDER_SAT_EN.
// Rev    : 1.0
// ============================================================================
module ks_pipe_adder
   import ks_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   ks_pipe_adder_if.slave bus
);

   localparam int LVL = ks_levels(WIDTH);
`ifdef KS_PIPE_ADDER_SAT_EN
   localparam int AUXW = 2;
`else
   localparam int AUXW = 1;
`endif

   if (!ks_width_ok(WIDTH)) begin : g_bad_width
      $error("ks_pipe_adder: WIDTH must be a power of two from 4 to 64");
   end

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] sum_q,       sum_d;
   logic             cout_q,      cout_d;
   logic             ovf_q,       ovf_d;

   // One stall signal for the whole pipe: it moves whenever the output slot frees up.
   logic w_adv;
   assign w_adv        = !out_valid_q || bus.out_ready;
   assign bus.in_ready = w_adv;

   logic [WIDTH-1:0] w_bx;
   logic [AUXW-1:0]  w_aux_in;
   assign w_bx        = bus.b ^ {WIDTH{bus.sub}};
   assign w_aux_in[0] = bus.sub ? 1'b1 : bus.cin;
`ifdef KS_PIPE_ADDER_SAT_EN
   assign w_aux_in[1] = bus.sat;
`endif

   logic             s0_v_q,   s0_v_d;
   logic [WIDTH-1:0] s0_p_q,   s0_p_d;
   logic [WIDTH-1:0] s0_g_q,   s0_g_d;
   logic [AUXW-1:0]  s0_aux_q, s0_aux_d;

   always_comb begin
      s0_v_d   = s0_v_q;
      s0_p_d   = s0_p_q;
      s0_g_d   = s0_g_q;
      s0_aux_d = s0_aux_q;
      if (w_adv) begin
         s0_v_d   = bus.in_valid;
         s0_p_d   = bus.a ^ w_bx;
         s0_g_d   = bus.a & w_bx;
         s0_aux_d = w_aux_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_v_q   <= 1'b0;
         s0_p_q   <= '0;
         s0_g_q   <= '0;
         s0_aux_q <= '0;
      end else begin
         s0_v_q   <= s0_v_d;
         s0_p_q   <= s0_p_d;
         s0_g_q   <= s0_g_d;
         s0_aux_q <= s0_aux_d;
      end
   end

   logic             w_v   [0:LVL];
   logic [WIDTH-1:0] w_p   [0:LVL];
   logic [WIDTH-1:0] w_gg  [0:LVL];
   logic [WIDTH-1:0] w_pp  [0:LVL];
   logic [AUXW-1:0]  w_aux [0:LVL];

   // Carry-in folds into bit 0's generate, so the prefix G[i] is the carry out of bit i.
   assign w_v[0]   = s0_v_q;
   assign w_p[0]   = s0_p_q;
   assign w_pp[0]  = s0_p_q;
   assign w_gg[0]  = {s0_g_q[WIDTH-1:1], s0_g_q[0] | (s0_p_q[0] & s0_aux_q[0])};
   assign w_aux[0] = s0_aux_q;

   for (genvar lv = 0; lv < LVL; lv++) begin : g_level
      ks_prefix_level #(
         .WIDTH (WIDTH),
         .DIST  (1 << lv),
         .AUXW  (AUXW)
      ) u_level (
         .clk   (clk),
         .rst_n (rst_n),
         .adv_i (w_adv),
         .v_i   (w_v[lv]),
         .p_i   (w_p[lv]),
         .gg_i  (w_gg[lv]),
         .pp_i  (w_pp[lv]),
         .aux_i (w_aux[lv]),
         .v_o   (w_v[lv+1]),
         .p_o   (w_p[lv+1]),
         .gg_o  (w_gg[lv+1]),
         .pp_o  (w_pp[lv+1]),
         .aux_o (w_aux[lv+1])
      );
   end

   logic [WIDTH-1:0] w_c;
   logic [WIDTH-1:0] w_sum_raw;
   logic [WIDTH-1:0] w_sum_sel;
   logic             w_cout;
   logic             w_ovf;

   assign w_c       = {w_gg[LVL][WIDTH-2:0], w_aux[LVL][0]};
   assign w_sum_raw = w_p[LVL] ^ w_c;
   assign w_cout    = w_gg[LVL][WIDTH-1];
   // Carry into the MSB differing from carry out is the same test as equal
   // operand MSBs disagreeing with the sum MSB.
   assign w_ovf     = w_c[WIDTH-1] ^ w_cout;

`ifdef KS_PIPE_ADDER_SAT_EN
   localparam logic [63:0]      C_SAT_MAX64 = ks_sat_max(WIDTH);
   localparam logic [63:0]      C_SAT_MIN64 = ks_sat_min(WIDTH);
   localparam logic [WIDTH-1:0] C_SAT_MAX   = C_SAT_MAX64[WIDTH-1:0];
   localparam logic [WIDTH-1:0] C_SAT_MIN   = C_SAT_MIN64[WIDTH-1:0];
   // A wrapped negative sum means the true result overflowed positive.
   assign w_sum_sel = (w_aux[LVL][1] && w_ovf) ?
                      (w_sum_raw[WIDTH-1] ? C_SAT_MAX : C_SAT_MIN) : w_sum_raw;
`else
   assign w_sum_sel = w_sum_raw;
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      if (w_adv) begin
         out_valid_d = w_v[LVL];
         sum_d       = w_sum_sel;
         cout_d      = w_cout;
         ovf_d       = w_ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire
